// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART byte-stream command parser driving a synchronous memory port
//
// Decodes 'W' addr data (write, answers ACK 0x06) and 'R' addr (read, answers mem[addr]).
// Any other first byte answers NAK 0x15. Stalled packets are dropped after an inter-byte
// timeout; bytes arriving while a command is executing are dropped and flagged as overrun.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_rx_data, i_rx_done  received byte and its one-cycle strobe
//   o_tx_data, o_tx_start response byte (held until i_tx_done) and one-cycle send request
//   i_tx_done             transmitter finished
//   o_mem_addr/o_mem_wdata/o_mem_we/o_mem_re, i_mem_rdata  memory port (read data one cycle after o_mem_re)
//   o_busy                high while not idle
//   o_err, o_err_code     one-cycle error pulse; code 01 bad command, 10 timeout, 11 overrun

module uart_cmd_parser #(
  parameter int CLKS_PER_BIT  = 87,
  parameter int TIMEOUT_BYTES = 4,
  parameter int ADDR_WIDTH    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_mem_wdata,
  output logic                  o_mem_we,
  output logic                  o_mem_re,
  input  logic [7:0]            i_mem_rdata,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [1:0]            o_err_code
);

  localparam int TIMEOUT_CLKS = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;
  localparam int TW           = $clog2(TIMEOUT_CLKS);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_MEM_WR, S_MEM_RD, S_MEM_WAIT, S_SEND, S_WAIT_TX
  } state_t;

  state_t                r_state, w_state;
  logic                  r_is_wr, w_is_wr;
  logic [TW-1:0]         r_tmo, w_tmo;
  logic [7:0]            r_tx_data, w_tx_data;
  logic                  r_tx_start, w_tx_start;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [7:0]            r_mem_wdata, w_mem_wdata;
  logic                  r_mem_we, w_mem_we;
  logic                  r_mem_re, w_mem_re;
  logic                  r_busy, w_busy;
  logic                  r_err, w_err;
  logic [1:0]            r_err_code, w_err_code;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_is_wr     <= 1'b0;
      r_tmo       <= '0;
      r_tx_data   <= 8'h00;
      r_tx_start  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_state     <= w_state;
      r_is_wr     <= w_is_wr;
      r_tmo       <= w_tmo;
      r_tx_data   <= w_tx_data;
      r_tx_start  <= w_tx_start;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_we    <= w_mem_we;
      r_mem_re    <= w_mem_re;
      r_busy      <= w_busy;
      r_err       <= w_err;
      r_err_code  <= w_err_code;
    end
  end

  // Every output is computed one cycle ahead so that its register lines up with the
  // state it belongs to (e.g. o_mem_we is high exactly while in MEM_WR).
  always_comb begin
    w_state     = r_state;
    w_is_wr     = r_is_wr;
    w_tmo       = r_tmo;
    w_tx_data   = r_tx_data;
    w_tx_start  = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_err       = 1'b0;
    w_err_code  = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (i_rx_done) begin
          w_tmo = '0;
          if (i_rx_data == CMD_W || i_rx_data == CMD_R) begin
            w_is_wr = (i_rx_data == CMD_W);
            w_state = S_GET_ADDR;
          end else begin
            w_tx_data  = NAK;
            w_tx_start = 1'b1;
            w_err      = 1'b1;
            w_err_code = 2'b01;
            w_state    = S_SEND;
          end
        end
      end
      S_GET_ADDR, S_GET_DATA: begin
        if (i_rx_done) begin
          // A byte on the very cycle the counter expires still wins over the timeout.
          w_tmo = '0;
          if (r_state == S_GET_ADDR) begin
            w_mem_addr = ADDR_WIDTH'(i_rx_data);
            if (r_is_wr) begin
              w_state = S_GET_DATA;
            end else begin
              w_mem_re = 1'b1;
              w_state  = S_MEM_RD;
            end
          end else begin
            w_mem_wdata = i_rx_data;
            w_mem_we    = 1'b1;
            w_state     = S_MEM_WR;
          end
        end else if (r_tmo == TW'(TIMEOUT_CLKS - 1)) begin
          w_tmo      = '0;
          w_err      = 1'b1;
          w_err_code = 2'b10;
          w_state    = S_IDLE;
        end else begin
          w_tmo = r_tmo + 1'b1;
        end
      end
      S_MEM_WR: begin
        w_tx_data  = ACK;
        w_tx_start = 1'b1;
        w_state    = S_SEND;
      end
      S_MEM_RD: begin
        w_state = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        w_tx_data  = i_mem_rdata;
        w_tx_start = 1'b1;
        w_state    = S_SEND;
      end
      S_SEND: begin
        w_state = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_tx_done) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    // Bytes arriving while a command executes are discarded without touching the FSM.
    if (i_rx_done && r_state inside {S_MEM_WR, S_MEM_RD, S_MEM_WAIT, S_SEND, S_WAIT_TX}) begin
      w_err      = 1'b1;
      w_err_code = 2'b11;
    end

    w_busy = (w_state != S_IDLE);
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;
  assign o_mem_re    = r_mem_re;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command engine directly downstream of `uart_controller`'s receiver and upstream of its transmitter. Consumes `rx_data`/`rx_done` bytes, decodes a 2- or 3-byte packet protocol (write byte / read byte), performs the access on a synchronous memory port, and returns a one-byte response through `tx_data`/`tx_start`/`tx_done`. Aborts stalled packets with an inter-byte timeout and reports errors on a status pulse.

## Interface
- `CLKS_PER_BIT`, 87: UART bit time in clocks; used only to size the timeout.
- `TIMEOUT_BYTES`, 4: inter-byte timeout in character times; `TIMEOUT_CLKS = CLKS_PER_BIT*10*TIMEOUT_BYTES` (3480 at defaults).
- `ADDR_WIDTH`, 8: memory address width (256 locations).

- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_done`=1.
- `rx_done`  in  1  one-cycle pulse per received byte.
- `tx_data`  out  8  response byte; held stable from `tx_start` until `tx_done`.
- `tx_start`  out  1  one-cycle pulse requesting transmission.
- `tx_done`  in  1  one-cycle pulse, transmitter finished.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  8  write data.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_re`  out  1  one-cycle read strobe; `mem_rdata` valid exactly one cycle later.
- `mem_rdata`  in  8  read data.
- `busy`  out  1  high whenever state is not IDLE.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  01 bad command, 10 timeout, 11 overrun; valid while `err`=1, else 00.

## Operation
- Protocol: `W`(0x57), addr, data -> write, respond ACK 0x06. `R`(0x52), addr -> respond mem[addr]. Any other first byte -> respond NAK 0x15, `err_code`=01.
- States: IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, MEM_WAIT, SEND, WAIT_TX.
- IDLE: on `rx_done`, latch command; `W`/`R` -> GET_ADDR; else load NAK -> SEND.
- GET_ADDR: on `rx_done`, latch addr; `W` -> GET_DATA, `R` -> MEM_RD.
- GET_DATA: on `rx_done`, latch data -> MEM_WR.
- MEM_WR: `mem_we`=1 one cycle, load ACK -> SEND.
- MEM_RD: `mem_re`=1 one cycle -> MEM_WAIT; MEM_WAIT: capture `mem_rdata` into `tx_data` -> SEND.
- SEND: `tx_start`=1 one cycle -> WAIT_TX. WAIT_TX: on `tx_done` -> IDLE.
- Timeout: counter cleared on every accepted byte and on entry to GET_ADDR; increments in GET_ADDR/GET_DATA; at `TIMEOUT_CLKS` with no `rx_done` -> IDLE, `err`=1, `err_code`=10, no response, no memory access.
- Overrun: `rx_done` in MEM_WR, MEM_RD, MEM_WAIT, SEND or WAIT_TX -> byte dropped, `err`=1, `err_code`=11, state unaffected.
- Address uses the full `ADDR_WIDTH`; no wrap or range check. Command byte compare is exact (lower-case `w`/`r` are bad commands).

## Timing
- All outputs registered. Reset values: `tx_data`=0x00, `tx_start`=0, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `mem_re`=0, `busy`=0, `err`=0, `err_code`=00; state IDLE, timeout counter 0.
- Write: data byte `rx_done` in cycle T -> `mem_we`=1 in T+1 with `mem_addr`/`mem_wdata` valid -> `tx_start`=1, `tx_data`=0x06 in T+2.
- Read: addr byte `rx_done` in T -> `mem_re`=1 in T+1 -> `mem_rdata` sampled in T+2 -> `tx_start`=1 in T+3 with `tx_data`=read value.
- Bad command: `rx_done` in T -> `err`=1 and `tx_start`=1 (0x15) both in T+1.
- `tx_done` in WAIT_TX at cycle T -> IDLE at T+1; an `rx_done` in T+1 is accepted as a new command. `rx_done` coincident with `tx_done` counts as overrun.
- `rx_done` in the same cycle the counter reaches `TIMEOUT_CLKS`: byte is accepted, no timeout.
- `tx_done` outside WAIT_TX: ignored.
- `rst` mid-packet or mid-transmission: next cycle all outputs at reset values, state IDLE; no wait for the transmitter, and partial packets are discarded.

## Test plan
- `W`,0x10,0xA5 then `R`,0x10 -> `mem_we` pulse addr 0x10 data 0xA5, response 0x06; then `mem_re` addr 0x10, response 0xA5; latencies exactly T+1/T+2 and T+1/T+3.
- Byte 0x3C as command -> `err`=1 `err_code`=01, response 0x15, back to IDLE after `tx_done`; no memory strobe.
- `W`,0x20 then silence -> `err`=1 `err_code`=10 exactly 3480 clocks after the addr byte; no `mem_we`, no `tx_start`. Repeat with the data byte arriving on cycle 3480 -> write accepted.
- `R`,0x05 with extra byte 0x55 injected during WAIT_TX -> `err_code`=11 pulse, response unaffected, 0x55 not parsed.
- `rst` asserted after `W`,0x30 -> all outputs at reset values; following `R`,0x30 returns prior contents (no write occurred).
- Five back-to-back random write/read pairs at addresses 0x00 and 0xFF -> each read returns the last value written; `busy` low between packets.
